// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the delayed-FIFO family (fifo_with_delay, fifo_read_adapter).
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH   = 8;
    localparam int FIFO_READ_LATENCY = 4;

    // One entry per in-flight read plus one for the word currently presented downstream.
    function automatic int skid_depth_for(input int read_latency);
        return read_latency + 1;
    endfunction

    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/read_tag_pipe.sv
// Valid-only shift register tracking reads issued to the delayed FIFO; the last stage
// marks the edge at which the returning word is on fifo_data_out.
module read_tag_pipe
    import fifo_pkg::*;
#(
    parameter int STAGES = FIFO_READ_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    output logic [STAGES-1:0] o_tags,
    output logic              o_capture
);

    logic [STAGES-1:0] r_tags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tags <= '0;
        end else begin
            r_tags[0] <= i_read;
            for (int i = 1; i < STAGES; i++) begin
                r_tags[i] <= r_tags[i-1];
            end
        end
    end

    assign o_tags    = r_tags;
    assign o_capture = r_tags[STAGES-1];

endmodule

// File: rtl/fifo_read_adapter.sv
// Converts a fixed-latency FIFO read port into a valid/ready stream using read credits
// and a circular skid buffer that absorbs every word already requested.
module fifo_read_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = FIFO_DATA_WIDTH,
    parameter int READ_LATENCY = FIFO_READ_LATENCY,
    parameter int SKID_DEPTH   = skid_depth_for(READ_LATENCY)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_read_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [15:0]           words_out
);

    localparam int IW = $clog2(READ_LATENCY + 1) + 1;
    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    logic [READ_LATENCY-1:0] w_tags;
    logic                    w_capture;
    logic                    w_pop;
    logic                    w_credit_ok;
    logic                    w_read_en;
    logic [CW:0]             w_count_nxt;

    logic [IW-1:0]           r_inflight;
    logic [CW-1:0]           r_skid_count;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_skid [SKID_DEPTH];
    logic [15:0]             r_words_out;

    assign w_pop = (r_skid_count != '0) && m_ready;

    // A word leaving the buffer this cycle frees its credit immediately, which is what
    // lets the loop run at one word per cycle with only READ_LATENCY+1 entries.
    assign w_credit_ok = (int'(r_inflight) + int'(r_skid_count)) < (SKID_DEPTH + int'(w_pop));
    assign w_read_en   = !fifo_empty && w_credit_ok && !rst;

    read_tag_pipe #(
        .STAGES    (READ_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_read    (w_read_en),
        .o_tags    (w_tags),
        .o_capture (w_capture)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_read_en, w_capture})
                2'b10:   r_inflight <= r_inflight + IW'(1);
                2'b01:   r_inflight <= r_inflight - IW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // One bit wider than the counter so an overflow would be visible to the assertion.
    assign w_count_nxt = {1'b0, r_skid_count} + (CW+1)'(w_capture) - (CW+1)'(w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_skid[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_skid_count <= '0;
        end else begin
            if (w_capture) begin
                r_skid[r_wr_ptr] <= fifo_data_out;
                r_wr_ptr         <= PW'(wrap_inc(int'(r_wr_ptr), SKID_DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= PW'(wrap_inc(int'(r_rd_ptr), SKID_DEPTH));
            end
            r_skid_count <= w_count_nxt[CW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_words_out <= '0;
        end else if (w_pop) begin
            r_words_out <= r_words_out + 16'd1;
        end
    end

    assign fifo_read_en = w_read_en;
    assign m_valid      = (r_skid_count != '0);
    assign m_data       = r_skid[r_rd_ptr];
    assign words_out    = r_words_out;

    a_skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
        w_count_nxt <= (CW+1)'(SKID_DEPTH));

    a_inflight_matches_tags: assert property (@(posedge clk) disable iff (rst)
        int'(r_inflight) == $countones(w_tags));

endmodule
